// File: rtl/alu_rs_issue_pkg.sv
// Shared constants for the ALU reservation-station issue path: default geometry
// and the ALU opcode encoding carried in each entry's payload.
package alu_rs_issue_pkg;

    localparam int RS_ENT_NUM_D = 8;
    localparam int RS_SEL_D     = 3;
    localparam int DATA_LEN_D   = 32;
    localparam int ADDR_LEN_D   = 32;
    localparam int RRF_SEL_D    = 6;
    localparam int ALU_OP_LEN_D = 4;

    typedef enum logic [ALU_OP_LEN_D-1:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SLL  = 4'd1,
        ALU_OP_XOR  = 4'd4,
        ALU_OP_OR   = 4'd6,
        ALU_OP_AND  = 4'd7,
        ALU_OP_SRL  = 4'd5,
        ALU_OP_SEQ  = 4'd8,
        ALU_OP_SNE  = 4'd9,
        ALU_OP_SUB  = 4'd10,
        ALU_OP_SRA  = 4'd11,
        ALU_OP_SLT  = 4'd12,
        ALU_OP_SGE  = 4'd13,
        ALU_OP_SLTU = 4'd14,
        ALU_OP_SGEU = 4'd15
    } alu_op_e;

endpackage

// File: rtl/alu_rs_issue_rotate_prio_sel.sv
// Combinational rotating-priority selector: picks the first request at or above
// ptr, wrapping to 0. Shared by all reservation stations; N must be a power of two.
module rotate_prio_sel #(
    parameter int N   = 8,
    parameter int SEL = 3
) (
    input  logic [N-1:0]   req,
    input  logic [SEL-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [SEL-1:0] idx,
    output logic           any
);

    logic [SEL-1:0] probe;

    // Walk offsets from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        probe = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            probe = ptr + SEL'(i);
            if (req[probe]) begin
                any = 1'b1;
                idx = probe;
            end
        end
    end

    assign gnt = any ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;

endmodule

// File: rtl/alu_rs_issue.sv
// ALU reservation-station issue stage: rotating-priority pick of one ready entry
// per cycle into a single output register handshaked with the ALU.
module alu_rs_issue
    import alu_rs_issue_pkg::*;
#(
    parameter int RS_ENT_NUM = RS_ENT_NUM_D,
    parameter int RS_SEL     = RS_SEL_D,
    parameter int DATA_LEN   = DATA_LEN_D,
    parameter int ADDR_LEN   = ADDR_LEN_D,
    parameter int RRF_SEL    = RRF_SEL_D,
    parameter int ALU_OP_LEN = ALU_OP_LEN_D
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [RS_ENT_NUM-1:0]            busy_vec_i,
    input  logic [RS_ENT_NUM-1:0]            ready_vec_i,
    input  logic [RS_ENT_NUM*ADDR_LEN-1:0]   ent_pc_i,
    input  logic [RS_ENT_NUM*DATA_LEN-1:0]   ent_op_1_i,
    input  logic [RS_ENT_NUM*DATA_LEN-1:0]   ent_op_2_i,
    input  logic [RS_ENT_NUM*DATA_LEN-1:0]   ent_imm_i,
    input  logic [RS_ENT_NUM*RRF_SEL-1:0]    ent_rrf_tag_i,
    input  logic [RS_ENT_NUM-1:0]            ent_dst_i,
    input  logic [RS_ENT_NUM*ALU_OP_LEN-1:0] ent_alu_op_i,
    input  logic                             flush_i,
    input  logic                             alu_ready_i,
    output logic [RS_ENT_NUM-1:0]            grant_o,
    output logic                             issue_valid_o,
    output logic [ADDR_LEN-1:0]              issue_pc_o,
    output logic [DATA_LEN-1:0]              issue_op_1_o,
    output logic [DATA_LEN-1:0]              issue_op_2_o,
    output logic [DATA_LEN-1:0]              issue_imm_o,
    output logic [RRF_SEL-1:0]               issue_rrf_tag_o,
    output logic                             issue_dst_o,
    output logic [ALU_OP_LEN-1:0]            issue_alu_op_o,
    output logic [RS_SEL-1:0]                issue_ent_o
);

    logic [RS_ENT_NUM-1:0][ADDR_LEN-1:0]   pc_arr;
    logic [RS_ENT_NUM-1:0][DATA_LEN-1:0]   op_1_arr;
    logic [RS_ENT_NUM-1:0][DATA_LEN-1:0]   op_2_arr;
    logic [RS_ENT_NUM-1:0][DATA_LEN-1:0]   imm_arr;
    logic [RS_ENT_NUM-1:0][RRF_SEL-1:0]    tag_arr;
    logic [RS_ENT_NUM-1:0][ALU_OP_LEN-1:0] alu_op_arr;

    assign pc_arr     = ent_pc_i;
    assign op_1_arr   = ent_op_1_i;
    assign op_2_arr   = ent_op_2_i;
    assign imm_arr    = ent_imm_i;
    assign tag_arr    = ent_rrf_tag_i;
    assign alu_op_arr = ent_alu_op_i;

    logic [RS_SEL-1:0]     ptr;
    logic [RS_ENT_NUM-1:0] cand;
    logic [RS_ENT_NUM-1:0] sel_gnt;
    logic [RS_SEL-1:0]     sel_idx;
    logic                  sel_any;
    logic                  issue_en;
    logic                  issue_fire;

    assign cand = busy_vec_i & ready_vec_i;

    rotate_prio_sel #(
        .N   (RS_ENT_NUM),
        .SEL (RS_SEL)
    ) u_sel (
        .req (cand),
        .ptr (ptr),
        .gnt (sel_gnt),
        .idx (sel_idx),
        .any (sel_any)
    );

    // Reset gates the enable so no entry is told to free itself while held in reset.
    assign issue_en   = reset & ~flush_i & (~issue_valid_o | alu_ready_i);
    assign issue_fire = issue_en & sel_any;
    assign grant_o    = issue_fire ? sel_gnt : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_valid_o   <= 1'b0;
            ptr             <= '0;
            issue_ent_o     <= '0;
            issue_pc_o      <= '0;
            issue_op_1_o    <= '0;
            issue_op_2_o    <= '0;
            issue_imm_o     <= '0;
            issue_rrf_tag_o <= '0;
            issue_dst_o     <= 1'b0;
            issue_alu_op_o  <= '0;
        end else if (flush_i) begin
            issue_valid_o <= 1'b0;
        end else if (issue_fire) begin
            issue_valid_o   <= 1'b1;
            issue_ent_o     <= sel_idx;
            ptr             <= sel_idx + RS_SEL'(1);
            issue_pc_o      <= pc_arr[sel_idx];
            issue_op_1_o    <= op_1_arr[sel_idx];
            issue_op_2_o    <= op_2_arr[sel_idx];
            issue_imm_o     <= imm_arr[sel_idx];
            issue_rrf_tag_o <= tag_arr[sel_idx];
            issue_dst_o     <= ent_dst_i[sel_idx];
            issue_alu_op_o  <= alu_op_arr[sel_idx];
        end else if (issue_valid_o && alu_ready_i) begin
            issue_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_rs_issue.sv
// Directed bench for alu_rs_issue: stimulus pushes expected issues into a
// scoreboard, a negedge monitor pops and compares on each ALU handshake.
module tb_alu_rs_issue;

    logic         clk;
    logic         rst_n;
    logic [7:0]   busy;
    logic [7:0]   rdy;
    logic [255:0] pc_bus;
    logic [255:0] op1_bus;
    logic [255:0] op2_bus;
    logic [255:0] imm_bus;
    logic [47:0]  tag_bus;
    logic [7:0]   dst_bus;
    logic [31:0]  aop_bus;
    logic         flush;
    logic         alu_ready;
    logic [7:0]   grant;
    logic         valid;
    logic [31:0]  o_pc, o_op1, o_op2, o_imm;
    logic [5:0]   o_tag;
    logic         o_dst;
    logic [3:0]   o_aop;
    logic [2:0]   o_ent;

    int passed = 0;
    int total  = 0;
    int gen    = 0;

    typedef struct {
        int          ent;
        logic [31:0] pc, op1, op2, imm;
        logic [5:0]  tag;
        logic        dst;
        logic [3:0]  aop;
    } exp_t;

    exp_t q[$];

    alu_rs_issue dut (
        .clk             (clk),
        .reset           (rst_n),
        .busy_vec_i      (busy),
        .ready_vec_i     (rdy),
        .ent_pc_i        (pc_bus),
        .ent_op_1_i      (op1_bus),
        .ent_op_2_i      (op2_bus),
        .ent_imm_i       (imm_bus),
        .ent_rrf_tag_i   (tag_bus),
        .ent_dst_i       (dst_bus),
        .ent_alu_op_i    (aop_bus),
        .flush_i         (flush),
        .alu_ready_i     (alu_ready),
        .grant_o         (grant),
        .issue_valid_o   (valid),
        .issue_pc_o      (o_pc),
        .issue_op_1_o    (o_op1),
        .issue_op_2_o    (o_op2),
        .issue_imm_o     (o_imm),
        .issue_rrf_tag_o (o_tag),
        .issue_dst_o     (o_dst),
        .issue_alu_op_o  (o_aop),
        .issue_ent_o     (o_ent)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f_pc(int k, int g);
        return 32'h1000 + 32'(g) * 32'h100 + 32'(k) * 4;
    endfunction
    function automatic logic [31:0] f_op1(int k, int g);
        return 32'hA000_0000 + (32'(g) << 16) + 32'(k);
    endfunction
    function automatic logic [31:0] f_op2(int k, int g);
        return 32'hB000_0000 + (32'(g) << 16) + 32'(k) * 16;
    endfunction
    function automatic logic [31:0] f_imm(int k, int g);
        return 32'hC000_0000 + (32'(g) << 16) + 32'(k) * 3;
    endfunction
    function automatic logic [5:0] f_tag(int k, int g);
        return 6'(k * 5 + g);
    endfunction
    function automatic logic f_dst(int k, int g);
        return 1'((k ^ g) & 1);
    endfunction
    function automatic logic [3:0] f_aop(int k, int g);
        return 4'(k + g);
    endfunction

    task automatic set_entries(input int g);
        for (int k = 0; k < 8; k++) begin
            pc_bus[k*32 +: 32]  = f_pc(k, g);
            op1_bus[k*32 +: 32] = f_op1(k, g);
            op2_bus[k*32 +: 32] = f_op2(k, g);
            imm_bus[k*32 +: 32] = f_imm(k, g);
            tag_bus[k*6 +: 6]   = f_tag(k, g);
            dst_bus[k]          = f_dst(k, g);
            aop_bus[k*4 +: 4]   = f_aop(k, g);
        end
    endtask

    task automatic push(input int k);
        exp_t e;
        e.ent = k;
        e.pc  = f_pc(k, gen);
        e.op1 = f_op1(k, gen);
        e.op2 = f_op2(k, gen);
        e.imm = f_imm(k, gen);
        e.tag = f_tag(k, gen);
        e.dst = f_dst(k, gen);
        e.aop = f_aop(k, gen);
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_cand(input logic [7:0] c);
        busy = c;
        rdy  = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && valid && alu_ready && !flush) begin
            if (q.size() == 0) begin
                chk("unexpected_issue", {61'd0, o_ent}, 64'hFFFF);
            end else begin : pop
                exp_t e;
                e = q.pop_front();
                chk("mon_ent", o_ent, e.ent[2:0]);
                chk("mon_pc", o_pc, e.pc);
                chk("mon_op1", o_op1, e.op1);
                chk("mon_op2", o_op2, e.op2);
                chk("mon_imm", o_imm, e.imm);
                chk("mon_tag", o_tag, e.tag);
                chk("mon_dst", o_dst, e.dst);
                chk("mon_aop", o_aop, e.aop);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] oh;
        clk = 0; rst_n = 0; flush = 0; alu_ready = 1;
        set_cand(8'hFF);
        set_entries(0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", grant, 8'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_ent", o_ent, 3'd0);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_op1", o_op1, 32'h0);
        chk("rst_tag", o_tag, 6'h0);
        chk("rst_aop", o_aop, 4'h0);
        set_cand(8'h00);
        rst_n = 1;
        tick();

        // first issue from entry 2
        set_cand(8'h04); #1;
        chk("t1_grant", grant, 8'h04);
        push(2);
        tick();
        chk("t1_valid", valid, 1'b1);
        chk("t1_ent", o_ent, 3'd2);

        // rotation: ptr=3 picks 7, then wraps to 0
        set_cand(8'h83); #1;
        chk("rot_grant7", grant, 8'h80);
        push(7);
        tick();
        set_cand(8'h03); #1;
        chk("rot_grant0", grant, 8'h01);
        push(0);
        tick();

        // stall with entry 0 held; entry fields change underneath
        alu_ready = 0;
        set_cand(8'h06);
        gen = 1;
        set_entries(1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_grant", grant, 8'h00);
            chk("stall_ent", o_ent, 3'd0);
            chk("stall_pc", o_pc, 32'h1000);
            chk("stall_valid", valid, 1'b1);
            tick();
        end
        alu_ready = 1; #1;
        chk("unstall_grant", grant, 8'h02);
        push(1);
        tick();

        // flush beats a pending issue and the ALU handshake
        alu_ready = 0;
        set_cand(8'hFF);
        flush = 1; #1;
        chk("flush_grant", grant, 8'h00);
        q.delete(0);
        tick();
        flush = 0;
        set_cand(8'h00); #1;
        chk("flush_valid", valid, 1'b0);
        // ptr held at 2: from {0,1,4} the pick must be 4
        set_cand(8'h13);
        alu_ready = 1; #1;
        chk("flush_ptr_grant", grant, 8'h10);
        push(4);
        tick();
        set_cand(8'h80); #1;
        chk("to7_grant", grant, 8'h80);
        push(7);
        tick();

        // back-to-back from ptr 0
        set_cand(8'hFF);
        for (int i = 0; i < 8; i++) begin
            #1;
            oh = 8'b1 << i;
            chk("b2b_grant", grant, oh);
            chk("b2b_valid", valid, 1'b1);
            push(i);
            tick();
        end
        set_cand(8'h20); #1;
        chk("pre_rst_grant", grant, 8'h20);
        push(5);
        tick();

        // async reset mid-cycle while holding entry 5 stalled
        alu_ready = 0;
        set_cand(8'h00);
        q.delete(0);
        #2;
        rst_n = 0;
        #1;
        chk("arst_valid", valid, 1'b0);
        chk("arst_ent", o_ent, 3'd0);
        chk("arst_pc", o_pc, 32'h0);
        tick();
        rst_n = 1;
        set_cand(8'h41);
        alu_ready = 1; #1;
        chk("post_rst_grant", grant, 8'h01);
        push(0);
        tick();
        chk("post_rst_ent", o_ent, 3'd0);
        set_cand(8'h00);
        repeat (3) tick();
        chk("sb_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_rs_issue.md
# alu_rs_issue

Issue side of the ALU reservation station. Each cycle it scans the RS entries' busy/ready vectors with a rotating-priority selector and captures one ready entry's payload into an output pipeline register. That register feeds the ALU under a valid/ready handshake. It also returns a one-hot grant so the owning entry frees itself on the next edge. It sits between the RsAlu entry array, which is written by dispatch, and the ALU execute stage.

## Interface
Parameters:
- RS_ENT_NUM, 8: number of RS entries; power of two.
- RS_SEL, 3: log2(RS_ENT_NUM).
- DATA_LEN, 32: operand/immediate width.
- ADDR_LEN, 32: PC width.
- RRF_SEL, 6: RRF tag width.
- ALU_OP_LEN, 4: ALU opcode width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- busy_vec_i  in  RS_ENT_NUM  entry holds an instruction.
- ready_vec_i  in  RS_ENT_NUM  both operands of the entry are valid.
- ent_pc_i  in  RS_ENT_NUM*ADDR_LEN  flattened entry PCs; entry k occupies bits [k*ADDR_LEN +: ADDR_LEN].
- ent_op_1_i, ent_op_2_i, ent_imm_i  in  RS_ENT_NUM*DATA_LEN  flattened operands and immediate.
- ent_rrf_tag_i  in  RS_ENT_NUM*RRF_SEL  flattened destination tags.
- ent_dst_i  in  RS_ENT_NUM  entry writes a destination.
- ent_alu_op_i  in  RS_ENT_NUM*ALU_OP_LEN  flattened opcodes.
- flush_i  in  1  misprediction kill.
- alu_ready_i  in  1  ALU accepts the issued instruction this cycle.
- grant_o  out  RS_ENT_NUM  one-hot issued entry; the RS clears that entry's busy at the next edge.
- issue_valid_o  out  1  output register holds an instruction.
- issue_pc_o, issue_op_1_o, issue_op_2_o, issue_imm_o, issue_rrf_tag_o, issue_dst_o, issue_alu_op_o  out  field widths  registered payload.
- issue_ent_o  out  RS_SEL  index of the entry the payload came from, for debug.

## Operation
- Candidate set: cand = busy_vec_i & ready_vec_i.
- Selection: the first set bit of cand, searching from ptr upward with wrap to 0. ptr is an internal RS_SEL-bit register.
- Issue-enable: en = ~flush_i & (~issue_valid_o | alu_ready_i).
- grant_o is combinational and one-hot. It is nonzero only when en=1 and cand≠0. It is all-zero otherwise.
- On each edge:
  - If flush_i=1: issue_valid_o←0; ptr is held.
  - Else if a grant to entry k is issued: the payload is loaded from entry k, issue_valid_o←1, issue_ent_o←k, ptr←(k+1) mod RS_ENT_NUM.
  - Else if issue_valid_o=1 and alu_ready_i=1: issue_valid_o←0.
  - Else: hold all state.
- Payload registers load only on a grant. They are never cleared except by reset.
- Back-to-back issue: when valid=1, alu_ready_i=1 and cand≠0, the ALU consumes the current instruction and the next one loads on the same edge. This gives one instruction per cycle.
- Stall: when valid=1 and alu_ready_i=0, there is no grant. Payload and ptr are held stable.
- flush_i has priority over alu_ready_i and over a new issue.

## Timing
- Reset values: issue_valid_o=0; ptr=0; issue_ent_o=0; all payload outputs=0. grant_o=0 while reset is asserted.
- Latency: an entry that is ready in cycle N appears at issue_valid_o in cycle N+1, assuming en=1 in cycle N.
- An entry granted in cycle N must not show busy in cycle N+1 (RS contract). This block does not re-check it.
- Reset mid-stall: the output is cleared immediately and asynchronously. The instruction is lost; the RS is flushed by the same reset.

## Structure
- Shared header consts/Consts.v: ADDR_LEN, DATA_LEN, RRF_SEL, RS_ENT_NUM/RS_SEL.
- Shared header consts/ALU.v: ALU_OP_LEN and the opcode encodings.
- Sub-module rotate_prio_sel: a parameterised combinational rotating-priority encoder.
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant, index, and any-grant.
  - It is reusable by the other reservation stations.
- Flattened payload buses are used because the port style is Verilog-2001.

## Test plan
- Reset, then cand=8'b0000_0100 with alu_ready_i=1 → grant_o=8'b0000_0100 in cycle 0. In cycle 1: issue_valid_o=1, issue_ent_o=2, ptr=3, and the payload equals entry 2's fields.
- Rotation: ptr=3, cand=8'b1000_0011 → grant entry 7, then ptr=0. Next cycle with the same cand minus entry 7 → grant entry 0.
- Stall: valid=1, alu_ready_i=0 for 4 cycles with cand≠0 → grant_o=0 throughout; payload, issue_ent_o and ptr are unchanged. Raise alu_ready_i → a new grant the same cycle, and the new payload appears next edge.
- Flush: valid=1, cand=8'hFF, flush_i=1 → grant_o=0 that cycle, issue_valid_o=0 next edge, ptr unchanged.
- Back-to-back: cand=8'hFF held, alu_ready_i=1 for 8 cycles → issue_ent_o sequence 0,1,…,7. Each grant is one-hot and there is no idle cycle.
- Async reset asserted mid-cycle while valid=1 → issue_valid_o drops before the next clock edge. After release, the first issue searches from entry 0.
